// File: rtl/chroma_threshold_pipe_pkg.sv
// Shared types and defaults for the chroma window binariser.
// Threshold fields are stored at THR_W bits; narrower pixel widths are zero-extended.
package chroma_threshold_pipe_pkg;

  localparam int THR_W  = 16;

  localparam int DEF_TA = 90;
  localparam int DEF_TB = 200;
  localparam int DEF_TC = 90;
  localparam int DEF_TD = 200;

  typedef enum logic [1:0] {
    MODE_BINARY    = 2'd0,
    MODE_OVERLAY   = 2'd1,
    MODE_INVERT    = 2'd2,
    MODE_HIGHLIGHT = 2'd3
  } mode_e;

  // Cr window (ta, tb) and Cb window (tc, td), all exclusive bounds
  typedef struct packed {
    logic [THR_W-1:0] ta;
    logic [THR_W-1:0] tb;
    logic [THR_W-1:0] tc;
    logic [THR_W-1:0] td;
  } win_t;

  typedef struct packed {
    win_t  win;
    mode_e mode;
  } thr_set_t;

endpackage

// File: rtl/chroma_threshold_pipe_cmp.sv
// Combinational Cb/Cr window test: strict unsigned bounds, empty window never matches.
module chroma_window_cmp
  import chroma_threshold_pipe_pkg::*;
(
  input  logic [THR_W-1:0] cb,
  input  logic [THR_W-1:0] cr,
  input  win_t             win,
  output logic             mask
);

  logic empty;

  assign empty = (win.ta >= win.tb) || (win.tc >= win.td);
  assign mask  = ~empty & (cr > win.ta) & (cr < win.tb) & (cb > win.tc) & (cb < win.td);

endmodule

// File: rtl/chroma_threshold_pipe.sv
// Two-stage chroma-key binariser with frame-synchronous config commit and
// per-frame foreground pixel count; sync/DE delay-matched to the pixel path.
module chroma_threshold_pipe
  import chroma_threshold_pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 22,
  parameter int TA_DEF = DEF_TA,
  parameter int TB_DEF = DEF_TB,
  parameter int TC_DEF = DEF_TC,
  parameter int TD_DEF = DEF_TD,
  parameter bit VS_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] cb,
  input  logic [DATA_W-1:0] cr,
  input  logic [DATA_W-1:0] r_in,
  input  logic [DATA_W-1:0] g_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              de_in,
  input  logic              hdmi_hs_in,
  input  logic              hdmi_vs_in,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_ta,
  input  logic [DATA_W-1:0] cfg_tb,
  input  logic [DATA_W-1:0] cfg_tc,
  input  logic [DATA_W-1:0] cfg_td,
  input  logic [1:0]        cfg_mode,
  output logic [DATA_W-1:0] r_out,
  output logic [DATA_W-1:0] g_out,
  output logic [DATA_W-1:0] b_out,
  output logic              de_out,
  output logic              hdmi_hs_out,
  output logic              hdmi_vs_out,
  output logic [CNT_W-1:0]  frame_count,
  output logic              count_valid
);

  localparam logic [DATA_W-1:0] ONES = '1;
  localparam thr_set_t THR_RST = '{
    win:  '{ta: THR_W'(TA_DEF), tb: THR_W'(TB_DEF), tc: THR_W'(TC_DEF), td: THR_W'(TD_DEF)},
    mode: MODE_BINARY
  };

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [3*DATA_W-1:0] shade(input mode_e mode, input logic hit,
                                                input logic [3*DATA_W-1:0] rgb);
    case (mode)
      MODE_BINARY:  shade = hit ? {3{ONES}} : '0;
      MODE_OVERLAY: shade = hit ? rgb : '0;
      MODE_INVERT:  shade = hit ? '0 : {3{ONES}};
      default:      shade = hit ? {ONES, {(2*DATA_W){1'b0}}} : rgb;
    endcase
  endfunction

  logic [DATA_W-1:0]   cb_p1, cr_p1, r_p1, g_p1, b_p1;
  logic                vld_p1, hs_p1, vs_p1;
  logic [3*DATA_W-1:0] rgb_p2;
  logic                vld_p2, hs_p2, vs_p2;

  thr_set_t            act, shadow, cfg_set;
  logic                pending;
  logic [CNT_W-1:0]    cnt;
  logic                frame_start, xfer, win_hit, mask_p1;
  logic [3*DATA_W-1:0] rgb_nxt;

  // Stage 1: register raw video
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cb_p1  <= '0;
      cr_p1  <= '0;
      r_p1   <= '0;
      g_p1   <= '0;
      b_p1   <= '0;
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= ~VS_POL;
    end else begin
      cb_p1  <= cb;
      cr_p1  <= cr;
      r_p1   <= r_in;
      g_p1   <= g_in;
      b_p1   <= b_in;
      vld_p1 <= de_in;
      hs_p1  <= hdmi_hs_in;
      vs_p1  <= hdmi_vs_in;
    end
  end

  chroma_window_cmp u_cmp (
    .cb   (THR_W'(cb_p1)),
    .cr   (THR_W'(cr_p1)),
    .win  (act.win),
    .mask (win_hit)
  );

  assign mask_p1 = win_hit & vld_p1;

  always_comb begin
    rgb_nxt = '0;
    if (vld_p1) rgb_nxt = shade(act.mode, mask_p1, {r_p1, g_p1, b_p1});
  end

  // Stage 2: classified pixel and delayed timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p2 <= '0;
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b0;
      vs_p2  <= ~VS_POL;
    end else begin
      rgb_p2 <= rgb_nxt;
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  assign {r_out, g_out, b_out} = rgb_p2;
  assign de_out      = vld_p2;
  assign hdmi_hs_out = hs_p2;
  assign hdmi_vs_out = vs_p2;

  assign frame_start = (vs_p1 == VS_POL) && (vs_p2 != VS_POL);
  assign cfg_ready   = ~pending;
  assign xfer        = cfg_valid & cfg_ready;
  assign cfg_set     = '{
    win:  '{ta: THR_W'(cfg_ta), tb: THR_W'(cfg_tb), tc: THR_W'(cfg_tc), td: THR_W'(cfg_td)},
    mode: mode_e'(cfg_mode)
  };

  // A transfer is only possible with pending clear, so it never races a commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act     <= THR_RST;
      shadow  <= THR_RST;
      pending <= 1'b0;
    end else begin
      if (frame_start && pending) begin
        act     <= shadow;
        pending <= 1'b0;
      end
      if (xfer) begin
        shadow  <= cfg_set;
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      frame_count <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= frame_start;
      if (frame_start) begin
        frame_count <= cnt;
        cnt         <= '0;
      end else if (mask_p1) begin
        cnt <= sat_inc(cnt);
      end
    end
  end

endmodule

// File: tb/tb_chroma_threshold_pipe.sv
// Directed scoreboard bench for chroma_threshold_pipe (22-bit and 4-bit counter builds).
module tb_chroma_threshold_pipe;

  typedef struct packed {
    logic [7:0] ta, tb, tc, td;
    logic [1:0] mode;
  } mcfg_t;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic       de, hs, vs;
  } vout_t;

  localparam mcfg_t CFG_DEF = '{ta: 8'd90, tb: 8'd200, tc: 8'd90, td: 8'd200, mode: 2'd0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  cb = '0, cr = '0, r_in = '0, g_in = '0, b_in = '0;
  logic        de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_ta = '0, cfg_tb = '0, cfg_tc = '0, cfg_td = '0;
  logic [1:0]  cfg_mode = '0;

  logic [7:0]  r_out, g_out, b_out;
  logic        de_out, hs_out, vs_out, cfg_ready, count_valid;
  logic [21:0] frame_count;

  logic [7:0]  r4, g4, b4;
  logic        de4, hs4, vs4, cfg_ready4, count_valid4;
  logic [3:0]  frame_count4;

  int n_checks = 0;
  int n_fail   = 0;

  mcfg_t       m_act, m_shadow;
  logic        m_pend, m_mask_prev, m_fs_flag, m_prev_vs, m_cv;
  logic [21:0] m_cnt, m_fc;
  logic [3:0]  m_cnt4, m_fc4;
  vout_t       exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  chroma_threshold_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .cb(cb), .cr(cr), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .de_in(de_in), .hdmi_hs_in(hs_in), .hdmi_vs_in(vs_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ta(cfg_ta), .cfg_tb(cfg_tb), .cfg_tc(cfg_tc), .cfg_td(cfg_td), .cfg_mode(cfg_mode),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .de_out(de_out), .hdmi_hs_out(hs_out), .hdmi_vs_out(vs_out),
    .frame_count(frame_count), .count_valid(count_valid)
  );

  chroma_threshold_pipe #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cb(cb), .cr(cr), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .de_in(de_in), .hdmi_hs_in(hs_in), .hdmi_vs_in(vs_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready4),
    .cfg_ta(cfg_ta), .cfg_tb(cfg_tb), .cfg_tc(cfg_tc), .cfg_td(cfg_td), .cfg_mode(cfg_mode),
    .r_out(r4), .g_out(g4), .b_out(b4),
    .de_out(de4), .hdmi_hs_out(hs4), .hdmi_vs_out(vs4),
    .frame_count(frame_count4), .count_valid(count_valid4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_mask(input mcfg_t c, input logic [7:0] i_cb, input logic [7:0] i_cr,
                                      input logic i_de);
    return i_de && (i_cr > c.ta) && (i_cr < c.tb) && (i_cb > c.tc) && (i_cb < c.td);
  endfunction

  function automatic vout_t model_px(input mcfg_t c, input logic [7:0] i_cb, input logic [7:0] i_cr,
                                     input logic [7:0] i_r, input logic [7:0] i_g, input logic [7:0] i_b,
                                     input logic i_de, input logic i_hs, input logic i_vs);
    vout_t o;
    logic  m;
    m = model_mask(c, i_cb, i_cr, i_de);
    o.de = i_de;
    o.hs = i_hs;
    o.vs = i_vs;
    case (c.mode)
      2'd0:    {o.r, o.g, o.b} = m ? 24'hFFFFFF : 24'h000000;
      2'd1:    {o.r, o.g, o.b} = m ? {i_r, i_g, i_b} : 24'h000000;
      2'd2:    {o.r, o.g, o.b} = m ? 24'h000000 : 24'hFFFFFF;
      default: {o.r, o.g, o.b} = m ? 24'hFF0000 : {i_r, i_g, i_b};
    endcase
    if (!i_de) {o.r, o.g, o.b} = 24'h000000;
    return o;
  endfunction

  task automatic model_reset();
    m_act = CFG_DEF;
    m_shadow = CFG_DEF;
    m_pend = 1'b0;
    m_mask_prev = 1'b0;
    m_fs_flag = 1'b0;
    m_prev_vs = 1'b0;
    m_cv = 1'b0;
    m_cnt = '0;
    m_fc = '0;
    m_cnt4 = '0;
    m_fc4 = '0;
    exp_q.delete();
    tag_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rgb"}, {r_out, g_out, b_out}, 24'h0);
    chk({tag, "_tim"}, {de_out, hs_out, vs_out}, 3'b000);
    chk({tag, "_rdy"}, cfg_ready, 1'b1);
    chk({tag, "_cv"}, count_valid, 1'b0);
    chk({tag, "_fc"}, frame_count, 22'd0);
    chk({tag, "_fc4"}, {count_valid4, frame_count4}, 5'd0);
  endtask

  // One pixel clock: drive, update expectations, clock, compare
  task automatic px(input string tag, input logic [7:0] i_cb, input logic [7:0] i_cr,
                    input logic [7:0] i_r, input logic [7:0] i_g, input logic [7:0] i_b,
                    input logic i_de, input logic i_hs, input logic i_vs);
    logic  fs_now, pend_old;
    vout_t got, e;
    string t;
    cb = i_cb; cr = i_cr; r_in = i_r; g_in = i_g; b_in = i_b;
    de_in = i_de; hs_in = i_hs; vs_in = i_vs;
    fs_now = m_fs_flag;
    pend_old = m_pend;
    m_cv = fs_now;
    if (fs_now) begin
      m_fc = m_cnt;
      m_fc4 = m_cnt4;
      m_cnt = '0;
      m_cnt4 = '0;
    end else if (m_mask_prev) begin
      if (m_cnt != 22'h3FFFFF) m_cnt = m_cnt + 22'd1;
      if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
    end
    if (fs_now && pend_old) begin
      m_act = m_shadow;
      m_pend = 1'b0;
    end
    if (cfg_valid && !pend_old) begin
      m_shadow = '{ta: cfg_ta, tb: cfg_tb, tc: cfg_tc, td: cfg_td, mode: cfg_mode};
      m_pend = 1'b1;
    end
    m_mask_prev = model_mask(m_act, i_cb, i_cr, i_de);
    exp_q.push_back(model_px(m_act, i_cb, i_cr, i_r, i_g, i_b, i_de, i_hs, i_vs));
    tag_q.push_back(tag);
    m_fs_flag = i_vs && !m_prev_vs;
    m_prev_vs = i_vs;
    @(posedge clk);
    #1;
    if (exp_q.size() > 1) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      got = {r_out, g_out, b_out, de_out, hs_out, vs_out};
      chk({"pix_", t}, got, e);
    end
    chk({"rdy_", tag}, cfg_ready, !m_pend);
    chk({"cv_", tag}, count_valid, m_cv);
    chk({"fc_", tag}, frame_count, m_fc);
    chk({"cv4_", tag}, count_valid4, m_cv);
    chk({"fc4_", tag}, frame_count4, m_fc4);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px("idle", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic vsync_pulse();
    px("vs", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    px("vs", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    px("vs", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    px("vs", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_cfg(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tc,
                         input logic [7:0] td, input logic [1:0] mode);
    cfg_ta = ta; cfg_tb = tb; cfg_tc = tc; cfg_td = td; cfg_mode = mode;
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_state("rst0");
    #2 rst_n = 1'b1;
    idle(2);

    // First frame start after reset: partial (empty) count is still pulsed
    vsync_pulse();
    px("m0_mid",  8'd128, 8'd128, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 1'b0);
    px("m0_cb90", 8'd90,  8'd128, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 1'b0);
    px("m0_cr200",8'd128, 8'd200, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 1'b0);
    px("m0_in",   8'd199, 8'd91,  8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 1'b0);
    px("m0_blank",8'd128, 8'd128, 8'h11, 8'h22, 8'h33, 1'b0, 1'b1, 1'b0);

    // Mid-frame write, then a second request while pending
    set_cfg(8'd100, 8'd200, 8'd90, 8'd200, 2'd1);
    cfg_valid = 1'b1;
    px("cfg_wr", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    set_cfg(8'd10, 8'd200, 8'd90, 8'd200, 2'd2);
    px("cfg_busy", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    cfg_valid = 1'b0;
    px("old_cr95", 8'd128, 8'd95, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    vsync_pulse();
    px("new_cr95",  8'd128, 8'd95,  8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    px("new_cr150", 8'd128, 8'd150, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    px("new_blank", 8'd128, 8'd150, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0);

    // Write landing on the frame-start cycle waits for the following frame start
    px("vs_same", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    set_cfg(8'd90, 8'd200, 8'd90, 8'd200, 2'd0);
    cfg_valid = 1'b1;
    px("vs_same_wr", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    cfg_valid = 1'b0;
    px("vs_same", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    px("held_cr95",  8'd128, 8'd95,  8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    px("held_cr150", 8'd128, 8'd150, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    vsync_pulse();

    // 10 x 16 frame, p*7 mod 160 < 37 selects exactly 37 foreground pixels
    for (int ln = 0; ln < 10; ln++) begin
      for (int x = 0; x < 16; x++) begin
        int p;
        p = ln * 16 + x;
        px("frame", 8'd128, (((p * 7) % 160) < 37) ? 8'd128 : 8'd50,
           8'(p), 8'(p + 1), 8'(p + 2), 1'b1, 1'b0, 1'b0);
      end
      px("hblank", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
      px("hblank", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    end
    vsync_pulse();
    chk("frame37", frame_count, 22'd37);
    chk("frame_sat4", frame_count4, 4'd15);
    px("def_cr95", 8'd128, 8'd95, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);

    // Empty Cr window in INVERT mode
    set_cfg(8'd150, 8'd150, 8'd90, 8'd200, 2'd2);
    cfg_valid = 1'b1;
    px("cfg_empty", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    cfg_valid = 1'b0;
    vsync_pulse();
    px("emp_mid",   8'd128, 8'd128, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    px("emp_150",   8'd128, 8'd150, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    px("emp_151",   8'd128, 8'd151, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    px("emp_zero",  8'd0,   8'd0,   8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    px("emp_blank", 8'd128, 8'd128, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0);

    // HIGHLIGHT mode
    set_cfg(8'd90, 8'd200, 8'd90, 8'd200, 2'd3);
    cfg_valid = 1'b1;
    px("cfg_hl", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    cfg_valid = 1'b0;
    vsync_pulse();
    px("hl_in",    8'd128, 8'd128, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    px("hl_out",   8'd128, 8'd50,  8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    px("hl_blank", 8'd128, 8'd128, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame with a write still pending
    px("pre_rst", 8'd128, 8'd128, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    set_cfg(8'd10, 8'd200, 8'd90, 8'd200, 2'd1);
    cfg_valid = 1'b1;
    px("pre_rst_wr", 8'd128, 8'd128, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("rst_mid");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(1);
    px("post_rst_in",  8'd128, 8'd128, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    px("post_rst_out", 8'd128, 8'd60,  8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    idle(2);
    vsync_pulse();
    px("after_rst_fs", 8'd128, 8'd128, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
